qspi_sram_arbiter: RTL

Shares one QSPI serial SRAM controller (the 23LC1024 word-access engine) between two requesters: the Hack CPU data port (read/write) and the display refresh fetcher (read-only).
It sits between hack_soc's CPU/display logic and the single controller instance driving the VRAM chip.
The display has fixed priority, with a starvation limiter guaranteeing CPU progress.
It sequences exactly one controller transaction at a time and returns the result to the winning client.

---
 rtl/qspi_sram_arbiter_pkg.sv | 6 +
 rtl/qspi_sram_arbiter_if.sv | 24 ++
 rtl/qspi_sram_arbiter_select.sv | 26 ++
 rtl/qspi_sram_arbiter.sv | 77 +++++++
 4 files changed

// File: rtl/qspi_sram_arbiter_pkg.sv
// qspi_sram_arbiter_pkg: state, owner and timeout-fill encodings shared by the QSPI SRAM arbiter.
package qspi_arb_pkg;
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   localparam logic OWNER_CPU = 1'b0, OWNER_DISP = 1'b1;
   localparam logic TIMEOUT_FILL = 1'b1;
endpackage

// File: rtl/qspi_sram_arbiter_if.sv
// qspi_sram_arbiter_if: CPU/display client ports, controller ports and status for the QSPI SRAM arbiter.
interface qspi_sram_arbiter_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 16
);
   logic                  cpu_req, cpu_we, cpu_ack;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata;
   logic                  disp_req, disp_ack;
   logic [ADDR_WIDTH-1:0] disp_addr;
   logic [DATA_WIDTH-1:0] disp_rdata;
   logic                  ctrl_req, ctrl_we, ctrl_busy, ctrl_done;
   logic [ADDR_WIDTH-1:0] ctrl_addr;
   logic [DATA_WIDTH-1:0] ctrl_wdata, ctrl_rdata;
   logic                  arb_error;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, ctrl_busy, ctrl_done, ctrl_rdata,
      output cpu_ack, cpu_rdata, disp_ack, disp_rdata, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, arb_error
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, disp_req, disp_addr, ctrl_busy, ctrl_done, ctrl_rdata,
      input  cpu_ack, cpu_rdata, disp_ack, disp_rdata, ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, arb_error
   );
endinterface

// File: rtl/qspi_sram_arbiter_select.sv
// qspi_arb_select: display-priority winner selection with a streak limiter that guarantees CPU progress.
module qspi_arb_select
   import qspi_arb_pkg::*;
#(
   parameter int MAX_DISP_STREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_en,
   input  logic cpu_req,
   input  logic disp_req,
   output logic grant_valid,
   output logic grant_owner
);
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DISP_STREAK);
   logic [3:0] streak;
   logic       starved;
   assign starved     = cpu_req && streak == STREAK_MAX;
   assign grant_valid = cpu_req || disp_req;
   assign grant_owner = disp_req && !starved ? OWNER_DISP : OWNER_CPU;
   // Only display wins taken while the CPU waits count toward starvation.
   always_ff @(posedge clk)
      if (reset) streak <= '0;
      else if (grant_en && grant_valid)
         streak <= grant_owner == OWNER_DISP && cpu_req ? (streak == STREAK_MAX ? streak : streak + 4'd1) : '0;
endmodule

// File: rtl/qspi_sram_arbiter.sv
// qspi_sram_arbiter: runs one QSPI SRAM controller transaction at a time for the CPU or display fetcher.
// Defining QSPI_ARB_TIMEOUT_EN adds a WAIT watchdog that completes with all-ones data and sets arb_error.
module qspi_sram_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 17,
   parameter int DATA_WIDTH      = 16,
   parameter int MAX_DISP_STREAK = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input logic                clk,
   input logic                reset,
   qspi_sram_arbiter_if.slave bus
);
   logic [1:0]            state;
   logic                  owner, grant_valid, grant_owner, timeout;
   logic [ADDR_WIDTH-1:0] grant_addr;
   logic [DATA_WIDTH-1:0] result;
   qspi_arb_select #(.MAX_DISP_STREAK(MAX_DISP_STREAK)) u_sel (
      .clk         (clk),
      .reset       (reset),
      .grant_en    (state == IDLE),
      .cpu_req     (bus.cpu_req),
      .disp_req    (bus.disp_req),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );
   assign grant_addr   = grant_owner == OWNER_DISP ? bus.disp_addr : bus.cpu_addr;
   assign result       = timeout ? {DATA_WIDTH{TIMEOUT_FILL}} : bus.ctrl_rdata;
   assign bus.ctrl_req = state == ISSUE && !bus.ctrl_busy;
   assign bus.cpu_ack  = state == DONE && owner == OWNER_CPU;
   assign bus.disp_ack = state == DONE && owner == OWNER_DISP;
`ifdef QSPI_ARB_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              err;
   assign timeout       = state == WAIT && !bus.ctrl_done && wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1);
   assign bus.arb_error = err;
   always_ff @(posedge clk)
      if (reset) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
         if (timeout) err <= 1'b1;
      end
`else
   assign timeout       = 1'b0 && (TIMEOUT_CYCLES > 0);
   assign bus.arb_error = 1'b0;
`endif
   // Write completions leave cpu_rdata alone; display grants never write.
   always_ff @(posedge clk)
      if (reset) begin
         state          <= IDLE;
         owner          <= OWNER_CPU;
         bus.ctrl_we    <= 1'b0;
         bus.ctrl_addr  <= '0;
         bus.ctrl_wdata <= '0;
         bus.cpu_rdata  <= '0;
         bus.disp_rdata <= '0;
      end else case (state)
         IDLE: if (grant_valid) begin
            state         <= ISSUE;
            owner         <= grant_owner;
            bus.ctrl_we   <= grant_owner == OWNER_CPU && bus.cpu_we;
            bus.ctrl_addr <= grant_addr;
            if (grant_owner == OWNER_CPU) bus.ctrl_wdata <= bus.cpu_wdata;
         end
         ISSUE: if (!bus.ctrl_busy) state <= WAIT;
         WAIT: if (bus.ctrl_done || timeout) begin
            state <= DONE;
            if (owner == OWNER_DISP) bus.disp_rdata <= result;
            else if (!bus.ctrl_we) bus.cpu_rdata <= result;
         end
         default: state <= IDLE;
      endcase
endmodule
